// File: rtl/mult_div_pkg.sv
// Shared op codes and state encoding for the signed multi-cycle MULT/DIV sequencer.
package mult_div_pkg;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ITER  = 3'd1,
      ST_FIX   = 3'd2,
      ST_DONE  = 3'd3,
      ST_DZERO = 3'd4
   } state_t;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the datapath: shift-add for MULT, restoring subtract for DIV.
module mult_div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] mag_b,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] sr_next
);

   logic [WIDTH:0] addend;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      addend   = sr[0] ? {1'b0, mag_b} : '0;
      sum      = acc + addend;
      shifted  = {acc[WIDTH-1:0], sr[WIDTH-1]};
      diff     = shifted - {1'b0, mag_b};
      acc_next = acc;
      sr_next  = sr;
      if (op == OP_MULT) begin
         // product grows into acc while the multiplier shifts out of sr
         acc_next = {1'b0, sum[WIDTH:1]};
         sr_next  = {sum[0], sr[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_next = diff;
         sr_next  = {sr[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = shifted;
         sr_next  = {sr[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_sequencer.sv
// Signed multi-cycle MULT/DIV unit: FSM, iteration counter, sign flags and HI/LO registers.
//  state    | meaning
//  ST_IDLE  | waiting for start; operands latched as magnitudes on accept
//  ST_ITER  | one shift-add / restoring-subtract step per clock, WIDTH steps
//  ST_FIX   | sign correction of the unsigned result, HI/LO loaded on exit
//  ST_DONE  | done / hi_lo_write pulse
//  ST_DZERO | div_zero pulse, HI/LO untouched
module mult_div_sequencer
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             hi_lo_write,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic               op_q;
   logic               neg_q;
   logic               neg_a_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [WIDTH:0]     acc_q;
   logic [WIDTH-1:0]   sr_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     acc_next;
   logic [WIDTH-1:0]   sr_next;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // the most negative value maps to the unsigned magnitude 2^(WIDTH-1)
   assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

   mult_div_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_q),
      .acc      (acc_q),
      .sr       (sr_q),
      .mag_b    (mag_b_q),
      .acc_next (acc_next),
      .sr_next  (sr_next)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_DIV && operand_b == '0) state_next = ST_DZERO;
               else                                 state_next = ST_ITER;
            end
         end
         ST_ITER:  if (count == '0) state_next = ST_FIX;
         ST_FIX:   state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         ST_DZERO: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      product   = {acc_q[WIDTH-1:0], sr_q};
      product_s = neg_q ? -product : product;
      quot_s    = neg_q ? -sr_q : sr_q;
      rem_s     = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi    = (op_q == OP_MULT) ? product_s[2*WIDTH-1:WIDTH] : rem_s;
      fix_lo    = (op_q == OP_MULT) ? product_s[WIDTH-1:0]       : quot_s;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count   <= '0;
         op_q    <= OP_MULT;
         neg_q   <= 1'b0;
         neg_a_q <= 1'b0;
         mag_b_q <= '0;
         acc_q   <= '0;
         sr_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  neg_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                  neg_a_q <= operand_a[WIDTH-1];
                  mag_b_q <= abs_b;
                  sr_q    <= abs_a;
                  acc_q   <= '0;
                  count   <= CW'(WIDTH - 1);
               end
            end
            ST_ITER: begin
               acc_q <= acc_next;
               sr_q  <= sr_next;
               if (count != '0) count <= count - 1'b1;
            end
            ST_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);
   assign hi_lo_write = done;
   assign div_zero    = (state == ST_DZERO);
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: directed scenarios plus randomized ops against a plain-arithmetic model.
module tb_mult_div_sequencer;
   import mult_div_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         busy;
   logic         done;
   logic         hi_lo_write;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_hi   = '0;
   logic [W-1:0] exp_lo   = '0;

   mult_div_sequencer #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .hi_lo_write (hi_lo_write),
      .div_zero    (div_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: signed 64-bit arithmetic; C-style truncating division, remainder takes dividend sign.
   function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic dz, output logic [W-1:0] mh, output logic [W-1:0] ml);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      mh = exp_hi;
      ml = exp_lo;
      if (o == OP_MULT) begin
         p  = sa * sb;
         mh = p[63:32];
         ml = p[31:0];
      end else if (b == '0) begin
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         mh = r[31:0];
         ml = q[31:0];
      end
   endfunction

   task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Returns the number of negedges after the accepting edge until done/div_zero, or -1.
   task automatic wait_end(output int k);
      k = -1;
      for (int i = 0; i <= 60; i++) begin
         if (done || div_zero) begin
            k = i;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (hi_lo_write !== 1'b0) begin failures++; $display("FAIL rst_hlw got=%b exp=0", hi_lo_write); end
      checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL rst_dz got=%b exp=0", div_zero); end
      checks++; if (hi !== '0) begin failures++; $display("FAIL rst_hi got=%h exp=0", hi); end
      checks++; if (lo !== '0) begin failures++; $display("FAIL rst_lo got=%h exp=0", lo); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_mult_basic;
      int k;
      launch(OP_MULT, 32'd7, 32'hFFFFFFFD);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t1_latency got=%0d exp=%0d", k, LAT); end
      checks++; if (hi_lo_write !== 1'b1) begin failures++; $display("FAIL t1_hlw got=%b exp=1", hi_lo_write); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL t1_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL t1_lo got=%h exp=ffffffeb", lo); end
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_drop got=%b exp=0", busy); end
      exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFEB;
   endtask

   task automatic test_div_basic;
      int k;
      launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t2_latency got=%0d exp=%0d", k, LAT); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL t2_done got=%b exp=1", done); end
      checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL t2_lo got=%h exp=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL t2_hi got=%h exp=ffffffff", hi); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL t2_done_width got=%b exp=0", done); end
      exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
   endtask

   task automatic test_div_zero;
      int n_dz;
      int n_done;
      launch(OP_DIV, 32'd5, 32'd0);
      checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL t3_dz got=%b exp=1", div_zero); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL t3_hi_hold got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL t3_lo_hold got=%h exp=fffffffd", lo); end
      n_dz = 0; n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (div_zero) n_dz++;
         if (done || hi_lo_write) n_done++;
         @(negedge clock);
      end
      checks++; if (n_dz !== 1) begin failures++; $display("FAIL t3_dz_pulses got=%0d exp=1", n_dz); end
      checks++; if (n_done !== 0) begin failures++; $display("FAIL t3_no_done got=%0d exp=0", n_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_busy got=%b exp=0", busy); end
   endtask

   task automatic test_corners;
      int k;
      launch(OP_MULT, 32'h80000000, 32'h80000000);
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t4_mm_latency got=%0d exp=%0d", k, LAT); end
      checks++; if (hi !== 32'h40000000) begin failures++; $display("FAIL t4_mm_hi got=%h exp=40000000", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL t4_mm_lo got=%h exp=0", lo); end
      launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t4_md_latency got=%0d exp=%0d", k, LAT); end
      checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL t4_md_lo got=%h exp=80000000", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL t4_md_hi got=%h exp=0", hi); end
      exp_hi = 32'h0; exp_lo = 32'h80000000;
   endtask

   task automatic test_reset_mid;
      int k;
      launch(OP_MULT, 32'h00012345, 32'h00000777);
      repeat (9) @(negedge clock);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t5_busy_pre got=%b exp=1", busy); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL t5_done got=%b exp=0", done); end
      checks++; if (hi !== '0) begin failures++; $display("FAIL t5_hi got=%h exp=0", hi); end
      checks++; if (lo !== '0) begin failures++; $display("FAIL t5_lo got=%h exp=0", lo); end
      @(negedge clock);
      reset = 1'b0;
      exp_hi = '0; exp_lo = '0;
      launch(OP_MULT, 32'd3, 32'd4);
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t5_latency got=%0d exp=%0d", k, LAT); end
      checks++; if (lo !== 32'd12) begin failures++; $display("FAIL t5_lo_after got=%h exp=c", lo); end
      checks++; if (hi !== 32'd0) begin failures++; $display("FAIL t5_hi_after got=%h exp=0", hi); end
      exp_hi = 32'd0; exp_lo = 32'd12;
   endtask

   task automatic test_start_handling;
      int           n_done;
      int           k_done;
      int           k;
      logic [W-1:0] got_hi;
      logic [W-1:0] got_lo;
      logic         dz;
      logic [W-1:0] mh;
      logic [W-1:0] ml;
      launch(OP_MULT, 32'd1000, 32'hFFFFFF9C);
      n_done = 0; k_done = -1; got_hi = '0; got_lo = '0;
      for (int i = 0; i <= 33; i++) begin
         if (done) begin
            n_done++;
            if (k_done < 0) begin k_done = i; got_hi = hi; got_lo = lo; end
         end
         // stray starts: one during ITER, one sampled while in DONE
         start = (i == 5 || i == 33);
         op = OP_DIV; operand_a = $urandom; operand_b = '0;
         @(negedge clock);
      end
      start = 1'b0;
      checks++; if (n_done !== 1) begin failures++; $display("FAIL t6_done_count got=%0d exp=1", n_done); end
      checks++; if (k_done !== LAT) begin failures++; $display("FAIL t6_latency got=%0d exp=%0d", k_done, LAT); end
      checks++; if (got_hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL t6_hi got=%h exp=ffffffff", got_hi); end
      checks++; if (got_lo !== 32'hFFFE7960) begin failures++; $display("FAIL t6_lo got=%h exp=fffe7960", got_lo); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_done_start_ignored got=%b exp=0", busy); end
      exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFE7960;
      // state is IDLE right after DONE: this start is accepted
      start = 1'b1; op = OP_MULT; operand_a = 32'hFFFFFFF6; operand_b = 32'd11;
      @(negedge clock);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t6_accept_busy got=%b exp=1", busy); end
      model(OP_MULT, 32'hFFFFFFF6, 32'd11, dz, mh, ml);
      wait_end(k);
      checks++; if (k !== LAT) begin failures++; $display("FAIL t6_b2b_latency got=%0d exp=%0d", k, LAT); end
      checks++; if ({hi, lo} !== {mh, ml}) begin failures++; $display("FAIL t6_b2b_result got=%h_%h exp=%h_%h", hi, lo, mh, ml); end
      exp_hi = mh; exp_lo = ml;
   endtask

   task automatic test_random;
      int           k;
      int           sel;
      logic         o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         dz;
      logic [W-1:0] mh;
      logic [W-1:0] ml;
      for (int n = 0; n < 24; n++) begin
         o   = $urandom_range(0, 1) == 1 ? OP_DIV : OP_MULT;
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) b = '0;
         else if (sel == 1) a = 32'h80000000;
         else if (sel == 2) begin
            a = W'($signed($urandom_range(0, 200)) - 100);
            b = W'($signed($urandom_range(0, 20)) - 10);
         end
         model(o, a, b, dz, mh, ml);
         launch(o, a, b);
         // operands and op are ignored after the accepting edge
         op = $urandom_range(0, 1) == 1 ? OP_DIV : OP_MULT;
         operand_a = $urandom;
         operand_b = $urandom;
         wait_end(k);
         if (dz) begin
            checks++; if (k !== 0 || div_zero !== 1'b1) begin failures++; $display("FAIL rnd%0d_dz k=%0d dz=%b exp k=0 dz=1", n, k, div_zero); end
         end else begin
            checks++; if (k !== LAT || done !== 1'b1) begin failures++; $display("FAIL rnd%0d_done k=%0d done=%b exp k=%0d done=1", n, k, done, LAT); end
         end
         checks++;
         if ({hi, lo} !== {mh, ml}) begin
            failures++;
            $display("FAIL rnd%0d_result op=%b a=%h b=%h got=%h_%h exp=%h_%h", n, o, a, b, hi, lo, mh, ml);
         end
         exp_hi = mh; exp_lo = ml;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = OP_MULT; operand_a = '0; operand_b = '0;
      test_reset;
      test_mult_basic;
      test_div_basic;
      test_div_zero;
      test_corners;
      test_reset_mid;
      test_start_handling;
      test_random;
      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
